// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: opcode width, opcode values and a magnitude helper.
// Sits beside the ALU opcode package so decode logic can pull both from one place.
package mdu_pkg;

  localparam int MDU_OPT_WIDTH = 3;

  localparam logic [MDU_OPT_WIDTH-1:0] OPT_DISABLE = 3'd0;
  localparam logic [MDU_OPT_WIDTH-1:0] OPT_MULTU   = 3'd1;
  localparam logic [MDU_OPT_WIDTH-1:0] OPT_MULT    = 3'd2;
  localparam logic [MDU_OPT_WIDTH-1:0] OPT_DIVU    = 3'd3;
  localparam logic [MDU_OPT_WIDTH-1:0] OPT_DIV     = 3'd4;
  localparam logic [MDU_OPT_WIDTH-1:0] OPT_MTHI    = 3'd5;
  localparam logic [MDU_OPT_WIDTH-1:0] OPT_MTLO    = 3'd6;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is correct read as unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial subtract for divide.
// Purely combinational; the caller registers acc/q every RUN cycle.
module mdu_step (
  input  logic        is_div,
  input  logic [31:0] acc,
  input  logic [31:0] q,
  input  logic [31:0] m,
  output logic [31:0] acc_nxt,
  output logic [31:0] q_nxt
);

  logic [32:0] sum;
  logic [32:0] shifted;
  logic [32:0] trial;

  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : 33'd0);
    shifted = {acc, q[31]};
    trial   = shifted - {1'b0, m};
    if (is_div) begin
      // Remainder stays below the divisor, so bit 32 of trial is a clean borrow flag.
      if (!trial[32]) begin
        acc_nxt = trial[31:0];
        q_nxt   = {q[30:0], 1'b1};
      end else begin
        acc_nxt = shifted[31:0];
        q_nxt   = {q[30:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[32:1];
      q_nxt   = {sum[0], q[31:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// Sequential MIPS-style multiply/divide unit with HI/LO registers: 32 RUN steps, one FIX, one DONE.
// start is only sampled in IDLE; results are latched into hi/lo on the DONE edge.
module mdu_seq #(
  parameter int MDU_OPT_WIDTH = mdu_pkg::MDU_OPT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              opr1,
  input  logic [31:0]              opr2,
  input  logic [MDU_OPT_WIDTH-1:0] opt,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              hi,
  output logic [31:0]              lo,
  output logic                     illegal_opt,
  output logic                     div_by_zero
);

  import mdu_pkg::*;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] acc, q, m;
  logic [31:0] acc_nxt, q_nxt;
  logic        is_div, neg_q, neg_r;
  logic [31:0] res_hi, res_lo;
  logic        fin_dbz, fin_ill;
  logic        op_long;
  logic [63:0] prod;

  mdu_step u_step (
    .is_div  (is_div),
    .acc     (acc),
    .q       (q),
    .m       (m),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt)
  );

  assign busy = (state == S_RUN) || (state == S_FIX);
  assign prod = {acc, q};

  always_comb begin
    op_long = 1'b0;
    case (opt)
      OPT_MULTU, OPT_MULT: op_long = 1'b1;
      OPT_DIVU, OPT_DIV:   op_long = (opr2 != 32'd0);
      default:             op_long = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        // Divide-by-zero, MTHI/MTLO and illegal codes all finish through DONE without RUN.
        if (start) begin
          if (op_long)                  state_nxt = S_RUN;
          else if (opt != OPT_DISABLE)  state_nxt = S_DONE;
        end
      end
      S_RUN:   if (cnt == 5'd31) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 5'd0;
      acc         <= 32'd0;
      q           <= 32'd0;
      m           <= 32'd0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      res_hi      <= 32'd0;
      res_lo      <= 32'd0;
      fin_dbz     <= 1'b0;
      fin_ill     <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      done        <= 1'b0;
      illegal_opt <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      illegal_opt <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (opt != OPT_DISABLE)) begin
            fin_dbz <= 1'b0;
            fin_ill <= 1'b0;
            res_hi  <= hi;
            res_lo  <= lo;
            acc     <= 32'd0;
            case (opt)
              OPT_MULTU, OPT_MULT: begin
                is_div <= 1'b0;
                m      <= (opt == OPT_MULT) ? mag32(opr1) : opr1;
                q      <= (opt == OPT_MULT) ? mag32(opr2) : opr2;
                neg_q  <= (opt == OPT_MULT) && (opr1[31] ^ opr2[31]);
                neg_r  <= 1'b0;
              end
              OPT_DIVU, OPT_DIV: begin
                is_div <= 1'b1;
                m      <= (opt == OPT_DIV) ? mag32(opr2) : opr2;
                q      <= (opt == OPT_DIV) ? mag32(opr1) : opr1;
                neg_q  <= (opt == OPT_DIV) && (opr1[31] ^ opr2[31]);
                neg_r  <= (opt == OPT_DIV) && opr1[31];
                if (opr2 == 32'd0) begin
                  res_hi  <= opr1;
                  res_lo  <= 32'hFFFF_FFFF;
                  fin_dbz <= 1'b1;
                end
              end
              OPT_MTHI: begin
                hi     <= opr1;
                res_hi <= opr1;
              end
              OPT_MTLO: begin
                lo     <= opr1;
                res_lo <= opr1;
              end
              default: fin_ill <= 1'b1;
            endcase
          end
        end
        S_RUN: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          cnt <= cnt + 5'd1;
        end
        S_FIX: begin
          if (is_div) begin
            res_lo <= neg_q ? (32'd0 - q) : q;
            res_hi <= neg_r ? (32'd0 - acc) : acc;
          end else begin
            {res_hi, res_lo} <= neg_q ? (64'd0 - prod) : prod;
          end
        end
        S_DONE: begin
          if (fin_ill) begin
            illegal_opt <= 1'b1;
          end else begin
            hi          <= res_hi;
            lo          <= res_lo;
            done        <= 1'b1;
            div_by_zero <= fin_dbz;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq: scoreboard of expected hi/lo/div_by_zero popped on each done pulse.
module tb_mdu_seq;
  import mdu_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] opr1, opr2;
  logic [2:0]  opt;
  logic        busy, done, illegal_opt, div_by_zero;
  logic [31:0] hi, lo;

  int          n_chk  = 0;
  int          n_pass = 0;
  exp_t        sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mdu_seq dut (
    .clk         (clk),
    .rst         (rst),
    .opr1        (opr1),
    .opr2        (opr2),
    .opt         (opt),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .illegal_opt (illegal_opt),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Arithmetic reference built from native 64-bit operators.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb_v;
    logic [63:0] p;
    e.hi = m_hi; e.lo = m_lo; e.dbz = 1'b0;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    case (op)
      OPT_MULTU: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
      OPT_MULT:  begin p = 64'(sa * sb_v); e.hi = p[63:32]; e.lo = p[31:0]; end
      OPT_DIVU, OPT_DIV: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else if (op == OPT_DIVU) begin
          e.lo = a / b; e.hi = a % b;
        end else begin
          p = 64'(sa / sb_v); e.lo = p[31:0];
          p = 64'(sa % sb_v); e.hi = p[31:0];
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; opt = op; opr1 = a; opr2 = b;
    @(posedge clk); #1;
    start = 1'b0; opr1 = $urandom; opr2 = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e, input int lat, input int nbusy,
                        input bit disturb);
    int   cyc = 0;
    int   nb  = 0;
    exp_t got;
    sb.push_back(e);
    m_hi = e.hi; m_lo = e.lo;
    issue(op, a, b);
    while (done !== 1'b1 && cyc < 100) begin
      if (busy === 1'b1) nb++;
      if (disturb && cyc == 3) begin start = 1'b1; opt = OPT_MULTU; end
      if (disturb && cyc == 4) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " done seen"}, 64'(done), 64'd1);
    chk({tag, " latency"}, 64'(cyc), 64'(lat));
    chk({tag, " busy cycles"}, 64'(nb), 64'(nbusy));
    chk({tag, " busy at done"}, 64'(busy), 64'd0);
    got = sb.pop_front();
    chk({tag, " hi"}, 64'(hi), 64'(got.hi));
    chk({tag, " lo"}, 64'(lo), 64'(got.lo));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(got.dbz));
    @(posedge clk); #1;
    chk({tag, " done one cycle"}, 64'(done), 64'd0);
    chk({tag, " idle after"}, 64'(busy), 64'd0);
  endtask

  function automatic exp_t mk(input logic [31:0] h, input logic [31:0] l, input logic d);
    exp_t e;
    e.hi = h; e.lo = l; e.dbz = d;
    return e;
  endfunction

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    // Reset, with a start held alongside it that must be dropped.
    rst = 1'b1; start = 1'b1; opt = OPT_MTHI; opr1 = 32'h0000_DEAD; opr2 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst illegal", 64'(illegal_opt), 64'd0);
    chk("rst dbz", 64'(div_by_zero), 64'd0);
    rst = 1'b0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("start with rst dropped hi", 64'(hi), 64'd0);
    chk("start with rst no done", 64'(done), 64'd0);

    run_op("multu max*2", OPT_MULTU, 32'hFFFF_FFFF, 32'd2, mk(32'h1, 32'hFFFF_FFFE, 1'b0), 34, 33, 1'b0);
    run_op("mult -3*7", OPT_MULT, 32'hFFFF_FFFD, 32'd7, mk(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0), 34, 33, 1'b1);
    run_op("mult min*min", OPT_MULT, 32'h8000_0000, 32'h8000_0000, mk(32'h4000_0000, 32'h0, 1'b0), 34, 33, 1'b0);
    run_op("div -7/2", OPT_DIV, 32'hFFFF_FFF9, 32'd2, mk(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0), 34, 33, 1'b0);
    run_op("div 7/-2", OPT_DIV, 32'd7, 32'hFFFF_FFFE, mk(32'h1, 32'hFFFF_FFFD, 1'b0), 34, 33, 1'b0);
    run_op("div min/-1", OPT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, mk(32'h0, 32'h8000_0000, 1'b0), 34, 33, 1'b0);
    run_op("divu max/10", OPT_DIVU, 32'hFFFF_FFFF, 32'd10, mk(32'h5, 32'h1999_9999, 1'b0), 34, 33, 1'b1);
    run_op("divu 5/0", OPT_DIVU, 32'd5, 32'd0, mk(32'h5, 32'hFFFF_FFFF, 1'b1), 1, 0, 1'b0);
    run_op("mthi", OPT_MTHI, 32'h1234, 32'd0, mk(32'h1234, m_lo, 1'b0), 1, 0, 1'b0);
    run_op("mtlo", OPT_MTLO, 32'h5678, 32'd0, mk(32'h1234, 32'h5678, 1'b0), 1, 0, 1'b0);

    // Illegal opcode: one illegal_opt pulse, no done, hi/lo untouched.
    issue(3'd7, 32'hAAAA_AAAA, 32'h5555_5555);
    @(posedge clk); #1;
    chk("illegal pulse", 64'(illegal_opt), 64'd1);
    chk("illegal no done", 64'(done), 64'd0);
    @(posedge clk); #1;
    chk("illegal one cycle", 64'(illegal_opt), 64'd0);
    chk("illegal hi kept", 64'(hi), 64'h1234);
    chk("illegal lo kept", 64'(lo), 64'h5678);

    // DISABLE does nothing.
    issue(OPT_DISABLE, 32'hCAFE_F00D, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("disable no done", 64'(done | busy | illegal_opt), 64'd0);
      @(posedge clk); #1;
    end
    chk("disable hi kept", 64'(hi), 64'h1234);
    chk("disable lo kept", 64'(lo), 64'h5678);

    // Model-checked mix of arithmetic operations.
    for (int i = 0; i < 6; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = (i == 2) ? 32'd0 : $urandom_range(0, 3) == 0 ? 32'd3 : $urandom;
      if ((rop == OPT_DIVU || rop == OPT_DIV) && rb == 32'd0)
        run_op("mix", rop, ra, rb, model(rop, ra, rb), 1, 0, 1'b0);
      else
        run_op("mix", rop, ra, rb, model(rop, ra, rb), 34, 33, 1'b0);
    end

    // Reset in the middle of RUN.
    issue(OPT_MULT, 32'd5, 32'd9);
    repeat (10) @(posedge clk);
    #1;
    chk("midrun busy before rst", 64'(busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun rst busy", 64'(busy), 64'd0);
    chk("midrun rst done", 64'(done), 64'd0);
    chk("midrun rst hi", 64'(hi), 64'd0);
    chk("midrun rst lo", 64'(lo), 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    run_op("multu 3*4 after rst", OPT_MULTU, 32'd3, 32'd4, mk(32'h0, 32'd12, 1'b0), 34, 33, 1'b0);

    chk("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 The module SHALL have parameter MDU_OPT_WIDTH, default 3, meaning the width of opt, taken from the shared package.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port opr1, input, 32 bits: multiplicand or dividend; source operand for MTHI/MTLO.
REQ-005 The module SHALL have port opr2, input, 32 bits: multiplier or divisor.
REQ-006 The module SHALL have port opt, input, MDU_OPT_WIDTH bits: operation code.
REQ-007 The module SHALL have port start, input, 1 bit: request strobe, sampled only in IDLE.
REQ-008 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The module SHALL have port done, output, 1 bit: one-cycle pulse; hi and lo are valid in that cycle.
REQ-010 The module SHALL have port hi, output, 32 bits: HI register.
REQ-011 The module SHALL have port lo, output, 32 bits: LO register.
REQ-012 The module SHALL have port illegal_opt, output, 1 bit: one-cycle pulse after a start with an unknown opt.
REQ-013 The module SHALL have port div_by_zero, output, 1 bit: one-cycle pulse, coincident with done, for DIV/DIVU with opr2 == 0.

Function
REQ-014 Opcodes SHALL be: DISABLE=0, MULTU=1, MULT=2, DIVU=3, DIV=4, MTHI=5, MTLO=6; values 7 and up are illegal.
REQ-015 The FSM SHALL have states IDLE, RUN, FIX and DONE; reset enters IDLE.
REQ-016 When start=1 in IDLE at edge N with opt = MULT, MULTU, DIV or DIVU and opr2 != 0, the module SHALL latch the operand magnitudes and the result signs, then enter RUN.
REQ-017 RUN SHALL last exactly 32 cycles: one radix-2 shift-add (multiply) or restoring-subtract (divide) step per cycle, tracked by a 5-bit counter that wraps from 31 to 0 on exit.
REQ-018 FIX SHALL take 1 cycle and negate the product, quotient or remainder as signs require, then go to DONE.
REQ-019 busy SHALL be 1 for edges N+1 through N+33; done SHALL be 1 only in the cycle after edge N+34, with busy=0 and hi/lo updated at edge N+34.
REQ-020 Multiply results SHALL be {hi,lo} = the 64-bit product; MULT is two's-complement signed, MULTU is unsigned.
REQ-021 Divide results SHALL be lo = quotient and hi = remainder; DIV truncates toward zero and the remainder takes the dividend's sign.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0.
REQ-023 DIV/DIVU with opr2 == 0 SHALL not enter RUN; it SHALL go to DONE directly with hi = opr1, lo = 0xFFFFFFFF, and done and div_by_zero pulsing one cycle after edge N.
REQ-024 MTHI/MTLO SHALL write hi or lo from opr1 at edge N, leave the other register unchanged, and pulse done one cycle later; busy SHALL stay 0.
REQ-025 DISABLE, or start=0, SHALL cause no state change.
REQ-026 An illegal opt SHALL pulse illegal_opt one cycle later, leave hi/lo unchanged, and not pulse done.
REQ-027 start outside IDLE SHALL be ignored; operand and opt changes during RUN SHALL not affect the result.
REQ-028 hi and lo SHALL hold their values between operations.

Reset
REQ-029 rst=1 at any edge, including mid-RUN, SHALL force state IDLE, counter=0, hi=0, lo=0, and busy, done, illegal_opt and div_by_zero all 0.
REQ-030 A start asserted in the same cycle as rst SHALL be dropped.

Structure
REQ-031 The opcode constants and MDU_OPT_WIDTH SHALL live in a shared header next to the ALU opcode header; the FSM state encodings SHALL be local to the module.
REQ-032 There SHALL be one sub-module, mdu_step: a combinational single iteration (add-or-pass for multiply, trial subtract for divide) instantiated once.

Verification
REQ-033 MULTU with opr1=0xFFFFFFFF and opr2=2 -> done at cycle 34, hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 MULT with opr1=-3 and opr2=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
REQ-035 DIV with opr1=-7 and opr2=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV with opr1=0x80000000 and opr2=-1 -> lo=0x80000000, hi=0.
REQ-036 DIVU with opr1=5 and opr2=0 -> done and div_by_zero one cycle later, hi=5, lo=0xFFFFFFFF; a second start during busy is ignored.
REQ-037 MTHI with opr1=0x1234 then MTLO with opr1=0x5678 -> hi=0x1234, lo=0x5678; opt=7 -> illegal_opt pulse, hi/lo unchanged.
REQ-038 rst asserted at RUN cycle 10 -> the next cycle shows IDLE, busy=0 and hi=lo=0; a new MULTU with opr1=3 and opr2=4 then completes with lo=12.
